data_mem_bus: RTL and testbench

Parametrised, byte-addressed, little-endian data memory with a request/response handshake and configurable access latency. Supports RISC-V style sized accesses: byte, half and word stores with byte lanes, and signed or unsigned loads with extension. Detects misaligned and out-of-range accesses. Sits between the core's load/store stage and local RAM, and is the successor to the single-cycle word-only data memory.

---
 rtl/data_mem_bus.sv | 131 +++++++++++++
 tb/tb_data_mem_bus.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bus.sv
// Byte-addressed little-endian data memory with req/resp handshake,
// sized RISC-V loads/stores, fault detection and configurable latency.
module data_mem_bus #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [2:0]        size_q;
  logic [31:0]       wdata_q;

  logic [7:0] mem [DEPTH_BYTES];

  logic          size_ok, mis, oor, fault, access, wr_en;
  logic [AW-1:0] i0, i1, i2, i3;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   load_val;

  always_comb begin
    size_ok = 1'b0;
    unique case (size_q)
      3'b000, 3'b001, 3'b010,
      3'b100, 3'b101: size_ok = 1'b1;
      default:        size_ok = 1'b0;
    endcase
  end

  // Full-width compare: high addresses never alias into the array.
  assign mis = (size_q[1:0] == 2'b01 && addr_q[0])
            || (size_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
  assign oor    = addr_q >= DEPTH_A;
  assign fault  = !size_ok || mis || oor;
  assign access = (state == BUSY) && (cnt == 4'd0);
  assign wr_en  = access && we_q && !fault && !rst;

  assign i0 = addr_q[AW-1:0];
  assign i1 = i0 | AW'(1);
  assign i2 = i0 | AW'(2);
  assign i3 = i0 | AW'(3);
  assign b0 = mem[i0];
  assign b1 = mem[i1];
  assign b2 = mem[i2];
  assign b3 = mem[i3];

  always_comb begin
    load_val = 32'd0;
    unique case (1'b1)
      size_q == 3'b000: load_val = {{24{b0[7]}}, b0};
      size_q == 3'b001: load_val = {{16{b1[7]}}, b1, b0};
      size_q == 3'b010: load_val = {b3, b2, b1, b0};
      size_q == 3'b100: load_val = {24'd0, b0};
      size_q == 3'b101: load_val = {16'd0, b1, b0};
      default:          load_val = 32'd0;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_i) state_nx = BUSY;
      BUSY:    if (cnt == 4'd0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign ready_o = (state == IDLE);
  assign valid_o = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      wdata_q <= 32'd0;
      rdata_o <= 32'd0;
      err_o   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_i) begin
        addr_q  <= addr_i;
        we_q    <= we_i;
        size_q  <= size_i;
        wdata_q <= wdata_i;
        cnt     <= 4'(LATENCY - 1);
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        rdata_o <= (fault || we_q) ? 32'd0 : load_val;
        err_o   <= fault;
      end
    end
  end

  // Array is never cleared; lanes beyond the access size are untouched.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[i0] <= wdata_q[7:0];
      if (size_q[1:0] != 2'b00) mem[i1] <= wdata_q[15:8];
      if (size_q[1:0] == 2'b10) begin
        mem[i2] <= wdata_q[23:16];
        mem[i3] <= wdata_q[31:24];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_bus.sv
// Scoreboard bench for data_mem_bus: three instances with
// LATENCY 1, 4 and 3; expected responses queued at issue time.
module tb_data_mem_bus;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010;
  localparam logic [2:0] LBU = 3'b100, LHU = 3'b101, BADSZ = 3'b011;

  logic        clk;
  logic        rst [3];
  logic        req [3];
  logic        we  [3];
  logic [2:0]  sz  [3];
  logic [31:0] addr[3];
  logic [31:0] wd  [3];
  logic        rdy [3];
  logic        vld [3];
  logic [31:0] rd  [3];
  logic        err [3];

  logic [32:0] exp_q[3][$];
  int          acc_q[3][$];
  int          nacc[3];
  int          lacc[3];
  bit          held[3];
  bit          lheld[3];
  int          cyc;
  int          total;
  int          bad;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 4 : 3;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : inst
    data_mem_bus #(
      .DEPTH_BYTES(1024),
      .LATENCY(lat_of(g)),
      .ADDR_W(32)
    ) u_dut (
      .clk(clk),
      .rst(rst[g]),
      .req_i(req[g]),
      .we_i(we[g]),
      .size_i(sz[g]),
      .addr_i(addr[g]),
      .wdata_i(wd[g]),
      .ready_o(rdy[g]),
      .valid_o(vld[g]),
      .rdata_o(rd[g]),
      .err_o(err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int g,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s u%0d actual=%h required=%h", nm, g, act, exp);
    end
  endtask

  // Acceptance recorder: inputs and ready are stable mid low phase.
  always @(negedge clk) begin
    #2;
    for (int g = 0; g < 3; g++) begin
      if (req[g] && rdy[g] && !rst[g]) begin
        acc_q[g].push_back(cyc + 1);
        if (held[g] && lheld[g])
          chk("accept_spacing", g, cyc + 1 - lacc[g], lat_of(g) + 2);
        lheld[g] = held[g];
        lacc[g]  = cyc + 1;
        nacc[g]  = nacc[g] + 1;
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : mon
    logic [32:0] e;
    int          a;
    always @(negedge clk) begin
      if (vld[g]) begin
        if (exp_q[g].size() == 0 || acc_q[g].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid u%0d actual=%h required=none",
                   g, rd[g]);
        end else begin
          e = exp_q[g].pop_front();
          a = acc_q[g].pop_front();
          chk("rdata", g, rd[g], e[31:0]);
          chk("err", g, 32'(err[g]), 32'(e[32]));
          chk("latency", g, cyc - a, lat_of(g));
        end
      end
    end
  end

  task automatic issue(input int g, input logic w, input logic [2:0] s,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee,
                       input bit resp);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy[g] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[g]) begin
      total++;
      bad++;
      $display("FAIL ready_timeout u%0d actual=0 required=1", g);
      return;
    end
    if (resp) exp_q[g].push_back({ee, er});
    req[g]  = 1'b1;
    we[g]   = w;
    sz[g]   = s;
    addr[g] = a;
    wd[g]   = d;
    @(negedge clk);
    req[g]  = 1'b0;
  endtask

  task automatic ld(input int g, input logic [2:0] s, input logic [31:0] a,
                    input logic [31:0] er, input logic ee);
    issue(g, 1'b0, s, a, 32'd0, er, ee, 1'b1);
  endtask

  task automatic st(input int g, input logic [2:0] s, input logic [31:0] a,
                    input logic [31:0] d, input logic ee);
    issue(g, 1'b1, s, a, d, 32'd0, ee, 1'b1);
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    cyc   = 0;
    for (int g = 0; g < 3; g++) begin
      rst[g]   = 1'b1;
      req[g]   = 1'b0;
      we[g]    = 1'b0;
      sz[g]    = 3'd0;
      addr[g]  = 32'd0;
      wd[g]    = 32'd0;
      nacc[g]  = 0;
      lacc[g]  = 0;
      held[g]  = 1'b0;
      lheld[g] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_ready", g, 32'(rdy[g]), 32'd1);
      chk("rst_valid", g, 32'(vld[g]), 32'd0);
      chk("rst_err", g, 32'(err[g]), 32'd0);
      chk("rst_rdata", g, rd[g], 32'd0);
      rst[g] = 1'b0;
    end

    // LATENCY=1: basic store/load and ready timing
    st(0, LW, 32'h10, 32'hDEADBEEF, 1'b0);
    ld(0, LW, 32'h10, 32'hDEADBEEF, 1'b0);
    chk("busy_ready0", 0, 32'(rdy[0]), 32'd0);
    @(negedge clk);
    chk("busy_ready1", 0, 32'(rdy[0]), 32'd0);
    @(negedge clk);
    chk("ready_back", 0, 32'(rdy[0]), 32'd1);

    ld(0, LB,  32'h13, 32'hFFFFFFDE, 1'b0);
    ld(0, LBU, 32'h13, 32'h000000DE, 1'b0);
    ld(0, LH,  32'h10, 32'hFFFFBEEF, 1'b0);
    ld(0, LHU, 32'h12, 32'h0000DEAD, 1'b0);

    st(0, LB, 32'h11, 32'h12345655, 1'b0);
    ld(0, LW, 32'h10, 32'hDEAD55EF, 1'b0);
    st(0, LH, 32'h12, 32'h0000A5A5, 1'b0);
    ld(0, LW, 32'h10, 32'hA5A555EF, 1'b0);

    // Faults must not disturb memory
    ld(0, LW, 32'h12, 32'd0, 1'b1);
    ld(0, LH, 32'h11, 32'd0, 1'b1);
    ld(0, BADSZ, 32'h10, 32'd0, 1'b1);
    st(0, LW, 32'h400, 32'h01020304, 1'b1);
    st(0, LW, 32'h12, 32'hFFFFFFFF, 1'b1);
    st(0, LH, 32'h11, 32'hFFFFFFFF, 1'b1);
    st(0, BADSZ, 32'h10, 32'hFFFFFFFF, 1'b1);
    st(0, LW, 32'h80000010, 32'hFFFFFFFF, 1'b1);
    ld(0, LW, 32'h10, 32'hA5A555EF, 1'b0);
    ld(0, LW, 32'h400, 32'd0, 1'b1);
    st(0, LW, 32'h3FC, 32'h01020304, 1'b0);
    ld(0, LHU, 32'h3FE, 32'h00000102, 1'b0);
    ld(0, LB, 32'h3FF, 32'h00000001, 1'b0);

    // LATENCY=4: req held high continuously
    st(1, LW, 32'h0, 32'hCAFEF00D, 1'b0);
    n = 0;
    @(negedge clk);
    while (!rdy[1] && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 3; k++) exp_q[1].push_back({1'b0, 32'hCAFEF00D});
    begin
      int n0;
      n0 = nacc[1];
      held[1] = 1'b1;
      req[1]  = 1'b1;
      we[1]   = 1'b0;
      sz[1]   = LW;
      addr[1] = 32'h0;
      n = 0;
      while (nacc[1] < n0 + 3 && n < 100) begin
        @(negedge clk);
        n++;
      end
      req[1]  = 1'b0;
      held[1] = 1'b0;
      if (nacc[1] < n0 + 3) begin
        total++;
        bad++;
        $display("FAIL held_accepts u1 actual=%0d required=%0d",
                 nacc[1] - n0, 3);
      end
    end

    // LATENCY=3: reset while a store is pending
    st(2, LW, 32'h20, 32'h00000000, 1'b0);
    issue(2, 1'b1, LW, 32'h20, 32'h11111111, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst[2] = 1'b1;
    #1;
    acc_q[2].delete();
    chk("midrst_ready", 2, 32'(rdy[2]), 32'd1);
    chk("midrst_valid", 2, 32'(vld[2]), 32'd0);
    @(negedge clk);
    rst[2] = 1'b0;
    ld(2, LW, 32'h20, 32'h00000000, 1'b0);
    ld(2, LB, 32'h23, 32'h00000000, 1'b0);

    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0
           && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 0,
        32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'd0);
    repeat (8) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
